serial_subtractor: RTL and testbench
====================================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have one clock and a synchronous active-low reset: clk_i is the clock and rst_i is the reset, asserted low and sampled on the rising edge of clk_i.
REQ-002 Parameter: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-003 clk_i  input  1  rising-edge clock.
REQ-004 rst_i  input  1  synchronous reset, active low.
REQ-005 start_i  input  1  request to subtract; sampled each cycle.
REQ-006 In_A  input  WIDTH  minuend; captured when a start is accepted.
REQ-007 In_B  input  WIDTH  subtrahend; captured when a start is accepted.
REQ-008 Diff  output  WIDTH  result In_A - In_B, modulo 2^WIDTH.
REQ-009 Bout  output  1  unsigned borrow out (1 when In_A < In_B, unsigned).
REQ-010 Ovf  output  1  signed two's-complement overflow of the subtraction.
REQ-011 busy_o  output  1  high while a subtraction is in progress.
REQ-012 done_o  output  1  one-cycle pulse when Diff, Bout and Ovf become valid.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 In IDLE, start_i=1 SHALL capture In_A and In_B into shift registers, clear the borrow flop and the bit counter, and move to RUN.
REQ-015 In RUN, each cycle SHALL subtract one bit pair, LSB first, through the full subtractor using the registered borrow.
REQ-016 In RUN, each cycle SHALL shift the difference bit into the result register from the MSB end.
REQ-017 In RUN, each cycle SHALL update the borrow flop and increment the counter.
REQ-018 RUN SHALL last exactly WIDTH cycles, after which the FSM moves to DONE.
REQ-019 DONE SHALL last one cycle, with done_o=1; Diff, Bout and Ovf are valid from that cycle.
REQ-020 Latency: if start is accepted at edge N, done_o SHALL be high during the cycle after edge N+WIDTH.
REQ-021 Bout SHALL equal the final borrow flop value.
REQ-022 Ovf SHALL equal the borrow into the MSB XOR the borrow out of the MSB, captured on the last RUN cycle.
REQ-023 Diff, Bout and Ovf SHALL hold their values after DONE until the next accepted start.
REQ-024 During RUN, Diff, Bout and Ovf SHALL hold the previous result; their internal shift register is separate.
REQ-025 busy_o SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-026 start_i SHALL be ignored while busy_o=1, and the operands in flight SHALL NOT change.
REQ-027 start_i=1 during DONE SHALL be accepted: the operands are captured and the FSM goes directly to RUN, so back-to-back operations have WIDTH+1 cycles per result.
REQ-028 From DONE with start_i=0, the FSM SHALL return to IDLE.
REQ-029 Equal operands SHALL give Diff=0, Bout=0 and Ovf=0.
REQ-030 A WIDTH-bit counter wrap SHALL NOT be possible; the counter width is clog2(WIDTH)+1.

Reset
REQ-031 While rst_i=0 at a clock edge, the FSM SHALL go to IDLE and the counter, borrow flop and shift registers SHALL clear.
REQ-032 During reset, Diff, Bout, Ovf, busy_o and done_o SHALL be 0.
REQ-033 Reset asserted mid-RUN SHALL abort the operation with no done_o pulse; the first cycle after reset release is IDLE.

Structure
REQ-034 The shared package SHALL hold the FSM state encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the default WIDTH constant.
REQ-035 The one-bit full_subtractor sub-module SHALL be instantiated once.
REQ-036 full_subtractor SHALL be combinational, with inputs In_A, In_B, Bin and outputs Diff, Bout, built from two half subtractors and an OR.
REQ-037 All sequential logic SHALL be in serial_subtractor.

Verification (WIDTH=8)
REQ-038 Reset, then start with A=0x05, B=0x03 -> done_o high 9 cycles after the start edge; Diff=0x02, Bout=0, Ovf=0.
REQ-039 A=0x03, B=0x05 -> Diff=0xFE, Bout=1, Ovf=0; A=0x80, B=0x01 -> Diff=0x7F, Bout=0, Ovf=1.
REQ-040 Start A=0x10, B=0x01; pulse start_i with A=0xFF, B=0xFF at RUN cycle 3 -> result Diff=0x0F, and exactly one done_o pulse.
REQ-041 Hold start_i=1 continuously with alternating operands -> done_o every 9 cycles, and each result matches its captured operands.
REQ-042 Drive rst_i=0 for one cycle at RUN cycle 4 -> no done_o; all outputs 0; the next start produces the correct result.
REQ-043 Random 1000 operand pairs, checked against a reference model -> Diff, Bout and Ovf all match.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding,
// default operand width and the bit-counter width helper.
package serial_subtractor_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // One extra bit over clog2 so the counter can never wrap inside a run.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit combinational full subtractor: two half subtractors plus an OR
// merging their borrows.
module full_subtractor (
  input  logic In_A,
  input  logic In_B,
  input  logic Bin,
  output logic Diff,
  output logic Bout
);

  logic w_hs1_diff;
  logic w_hs1_bout;
  logic w_hs2_bout;

  // First half subtractor: A - B
  assign w_hs1_diff = In_A ^ In_B;
  assign w_hs1_bout = ~In_A & In_B;

  // Second half subtractor: (A - B) - Bin
  assign Diff       = w_hs1_diff ^ Bin;
  assign w_hs2_bout = ~w_hs1_diff & Bin;

  assign Bout = w_hs1_bout | w_hs2_bout;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes In_A - In_B one bit per cycle, LSB first,
// through a single full subtractor and a registered borrow. Results are
// published to the output registers only on the last RUN cycle, so the
// previous result stays visible while a new operation is in flight.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] In_A,
  input  logic [WIDTH-1:0] In_B,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic             w_busy;
  logic             w_done;
  logic             w_fs_diff;
  logic             w_fs_bout;

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  full_subtractor u_fs (
    .In_A (r_a[0]),
    .In_B (r_b[0]),
    .Bin  (r_borrow),
    .Diff (w_fs_diff),
    .Bout (w_fs_bout)
  );

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode, start acceptance and status flags
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_busy   = 1'b0;
    w_done   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start_i) begin
          w_next   = RUN;
          w_accept = 1'b1;
        end
      end
      RUN: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        w_done = 1'b1;
        if (start_i) begin
          w_next   = RUN;
          w_accept = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, serial shifting, borrow and bit counter
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a      <= In_A;
      r_b      <= In_B;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (r_state == RUN) begin
      r_a      <= r_a >> 1;
      r_b      <= r_b >> 1;
      r_res    <= {w_fs_diff, r_res[WIDTH-1:1]};
      r_borrow <= w_fs_bout;
      r_cnt    <= r_cnt + CW'(1);
    end
  end

  // Result publish on the final RUN cycle; holds until the next completion
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_diff <= '0;
      r_bout <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (r_state == RUN && w_last) begin
      r_diff <= {w_fs_diff, r_res[WIDTH-1:1]};
      r_bout <= w_fs_bout;
      r_ovf  <= r_borrow ^ w_fs_bout;
    end
  end

  // Outputs forced low for the whole reset cycle, not just after the edge
  assign Diff   = rst_i ? r_diff : '0;
  assign Bout   = rst_i & r_bout;
  assign Ovf    = rst_i & r_ovf;
  assign busy_o = rst_i & w_busy;
  assign done_o = rst_i & w_done;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): stimulus pushes the
// expected result when a start is issued, a negedge monitor pops on done_o.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;
  logic         busy;
  logic         done;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   cyc = 0;
  int   last_done_cyc = -1;
  bit   chk_period = 1'b0;
  int   base;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .start_i (start),
    .In_A    (a),
    .In_B    (b),
    .Diff    (diff),
    .Bout    (bout),
    .Ovf     (ovf),
    .busy_o  (busy),
    .done_o  (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e.d  = x - y;
    e.bo = (x < y);
    e.ov = (x[W-1] != y[W-1]) && (e.d[W-1] != x[W-1]);
    return e;
  endfunction

  // Monitor: pop and compare on every done pulse
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (chk_period && last_done_cyc >= 0) check("period", cyc - last_done_cyc, W + 1);
      last_done_cyc = cyc;
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = q.pop_front();
        check("diff", diff, mon_e.d);
        check("bout", bout, mon_e.bo);
        check("ovf", ovf, mon_e.ov);
      end
    end
  end

  task automatic wait_ready();
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (!busy) return;
    end
    check("ready_timeout", 1, 0);
  endtask

  task automatic drain();
    repeat (W + 4) @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input exp_t e,
                       input bit push, input bit lat);
    int j;
    wait_ready();
    start = 1'b1;
    a = x;
    b = y;
    if (push) q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    if (lat) begin
      for (j = 0; j < int'(W) + 4; j++) begin
        @(negedge clk);
        if (done) break;
      end
      check("latency", j, W);
    end
  endtask

  initial begin
    logic [W-1:0] rx;
    logic [W-1:0] ry;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed vectors
    do_op(8'h05, 8'h03, exp_t'({8'h02, 1'b0, 1'b0}), 1'b1, 1'b1);
    do_op(8'h03, 8'h05, exp_t'({8'hFE, 1'b1, 1'b0}), 1'b1, 1'b0);
    do_op(8'h80, 8'h01, exp_t'({8'h7F, 1'b0, 1'b1}), 1'b1, 1'b0);
    do_op(8'h5A, 8'h5A, exp_t'({8'h00, 1'b0, 1'b0}), 1'b1, 1'b0);
    do_op(8'h00, 8'hFF, exp_t'({8'h01, 1'b1, 1'b0}), 1'b1, 1'b0);
    do_op(8'h7F, 8'hFF, exp_t'({8'h80, 1'b1, 1'b1}), 1'b1, 1'b0);

    // Start pulse during RUN is ignored; previous result held meanwhile
    drain();
    base = done_cnt;
    start = 1'b1;
    a = 8'h10;
    b = 8'h01;
    q.push_back(exp_t'({8'h0F, 1'b0, 1'b0}));
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    a = 8'hFF;
    b = 8'hFF;
    check("hold_diff", diff, 8'h80);
    check("hold_bout", bout, 1);
    check("hold_busy", busy, 1);
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();
    check("single_done", done_cnt - base, 1);
    check("idle_busy", busy, 0);

    // Start held high with alternating operands
    base = done_cnt;
    last_done_cyc = -1;
    chk_period = 1'b1;
    start = 1'b1;
    a = 8'h55;
    b = 8'hAA;
    q.push_back(exp_t'({8'hAB, 1'b1, 1'b1}));
    @(posedge clk);
    for (int i = 1; i < 6; i++) begin
      #1;
      if (i % 2 == 1) begin
        a = 8'hAA;
        b = 8'h55;
        q.push_back(exp_t'({8'h55, 1'b0, 1'b1}));
      end else begin
        a = 8'h55;
        b = 8'hAA;
        q.push_back(exp_t'({8'hAB, 1'b1, 1'b1}));
      end
      repeat (W + 1) @(posedge clk);
    end
    #1;
    start = 1'b0;
    drain();
    chk_period = 1'b0;
    check("b2b_count", done_cnt - base, 6);

    // Reset mid-RUN aborts without a done pulse
    base = done_cnt;
    do_op(8'h33, 8'h11, exp_t'('0), 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_diff", diff, 0);
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_diff", diff, 0);
    check("post_rst_bout", bout, 0);
    check("post_rst_ovf", ovf, 0);
    check("post_rst_busy", busy, 0);
    drain();
    check("abort_no_done", done_cnt - base, 0);
    do_op(8'h33, 8'h11, exp_t'({8'h22, 1'b0, 1'b0}), 1'b1, 1'b1);

    // Random operand pairs against the reference model
    for (int i = 0; i < 1000; i++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      do_op(rx, ry, model(rx, ry), 1'b1, 1'b0);
    end
    drain();
    check("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
